acc_cpu_core: RTL and testbench

Parametrised accumulator processor core; successor to the fixed 8-bit, three-phase literal-only accumulator machine. Fetches `4+DATA_W`-bit instructions from an external single-port instruction memory through a request/valid handshake, holds a program counter, and executes arithmetic, logic and shift operations plus conditional jumps. It also has a halt state. Sits between the instruction ROM/RAM and the board-level LED/debug outputs.

---
 rtl/acc_cpu_core.sv | 160 ++++++++++++++++
 tb/tb_acc_cpu_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator core: two-cycle fetch/execute over a
// request/valid instruction port, with flags, conditional jumps and halt.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              instr_valid,
    input  logic [DATA_W+3:0] instr_data,
    output logic [DATA_W-1:0] acc_out,
    output logic              zero_f,
    output logic              carry_f,
    output logic              negative_f,
    output logic              overflow_f,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3, OP_LDI = 4'h4, OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6, OP_XOR = 4'h7, OP_ADC = 4'h8;
    localparam logic [3:0] OP_SBC = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC, OP_JN  = 4'hD, OP_HLT = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W+3:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

    logic [3:0]        op;
    logic [DATA_W-1:0] lit, res;
    logic [DATA_W:0]   sum, diff;
    logic              cin, c_new, v_new, alu_wr, take;

    assign op  = ir_q[DATA_W+3:DATA_W];
    assign lit = ir_q[DATA_W-1:0];
    assign cin = ((op == OP_ADC) || (op == OP_SBC)) ? c_q : 1'b0;
    assign sum = {1'b0, acc_q} + {1'b0, lit} + {{DATA_W{1'b0}}, cin};
    // Bit DATA_W of the widened difference is the borrow.
    assign diff = {1'b0, lit} - {1'b0, acc_q} - {{DATA_W{1'b0}}, cin};

    always_comb begin
        res    = acc_q;
        c_new  = 1'b0;
        v_new  = 1'b0;
        alu_wr = 1'b0;
        take   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                res    = sum[DATA_W-1:0];
                c_new  = sum[DATA_W];
                v_new  = (acc_q[DATA_W-1] == lit[DATA_W-1]) &&
                         (res[DATA_W-1] != acc_q[DATA_W-1]);
                alu_wr = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                res    = diff[DATA_W-1:0];
                c_new  = diff[DATA_W];
                v_new  = (acc_q[DATA_W-1] != lit[DATA_W-1]) &&
                         (res[DATA_W-1] != lit[DATA_W-1]);
                alu_wr = 1'b1;
            end
            OP_AND: begin res = acc_q & lit; alu_wr = 1'b1; end
            OP_OR:  begin res = acc_q | lit; alu_wr = 1'b1; end
            OP_XOR: begin res = acc_q ^ lit; alu_wr = 1'b1; end
            OP_LDI: begin res = lit;         alu_wr = 1'b1; end
            OP_SHL: begin
                res    = {acc_q[DATA_W-2:0], 1'b0};
                c_new  = acc_q[DATA_W-1];
                alu_wr = 1'b1;
            end
            OP_SHR: begin
                res    = {1'b0, acc_q[DATA_W-1:1]};
                c_new  = acc_q[0];
                alu_wr = 1'b1;
            end
            OP_JMP:  take = 1'b1;
            OP_JZ:   take = z_q;
            OP_JC:   take = c_q;
            OP_JN:   take = n_q;
            default: take = 1'b0;
        endcase
    end

    assign fetch_req = rst_n && run && (state_q == S_FETCH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        n_d     = n_q;
        v_d     = v_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_req && instr_valid) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (alu_wr) begin
                    acc_d = res;
                    z_d   = (res == '0);
                    n_d   = res[DATA_W-1];
                    c_d   = c_new;
                    v_d   = v_new;
                end
                if (take) pc_d = lit[ADDR_W-1:0];
                state_d = (op == OP_HLT) ? S_HALT : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
        end
    end

    assign fetch_addr = pc_q;
    assign pc_out     = pc_q;
    assign acc_out    = acc_q;
    assign zero_f     = z_q;
    assign carry_f    = c_q;
    assign negative_f = n_q;
    assign overflow_f = v_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: instruction-level reference model checked every
// cycle, directed programs with literal results, then randomized traffic.
module tb_acc_cpu_core;

    logic        clk = 0;
    logic        rst_n, run, fetch_req, instr_valid;
    logic [5:0]  fetch_addr, pc_out;
    logic [11:0] instr_data;
    logic [7:0]  acc_out;
    logic        zero_f, carry_f, negative_f, overflow_f, halted;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .acc_out(acc_out), .zero_f(zero_f), .carry_f(carry_f),
        .negative_f(negative_f), .overflow_f(overflow_f),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Instruction memory and responder with configurable wait states
    logic [11:0] mem [64];
    int waits = 0, wcnt = 0;

    initial begin
        instr_valid = 0;
        instr_data  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (fetch_req === 1'b1) begin
                if (wcnt == 0) begin
                    instr_valid = 1;
                    instr_data  = mem[fetch_addr];
                end else begin
                    wcnt--;
                    instr_valid = 0;
                    instr_data  = 12'($urandom);
                end
            end else begin
                wcnt        = waits;
                instr_valid = ($urandom % 4 == 0);
                instr_data  = 12'($urandom);
            end
        end
    end

    // Instruction-level reference model
    int m_acc, m_pc, m_ir;
    bit m_z, m_c, m_n, m_v, m_pend, m_halt;

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic m_exec();
        int op, l, a, cin, r, s;
        bit wr;
        op  = m_ir >> 8;
        l   = m_ir & 255;
        a   = m_acc;
        cin = (op == 8 || op == 9) ? int'(m_c) : 0;
        wr  = 1;
        r   = a;
        case (op)
            0, 8: begin
                s = a + l + cin; r = s & 255; m_c = (s > 255);
                s = sx(a) + sx(l) + cin; m_v = (s > 127 || s < -128);
            end
            1, 9: begin
                s = l - a - cin; r = s & 255; m_c = (s < 0);
                s = sx(l) - sx(a) - cin; m_v = (s > 127 || s < -128);
            end
            2: begin r = a & l; m_c = 0; m_v = 0; end
            3: begin r = a | l; m_c = 0; m_v = 0; end
            4: begin r = l;     m_c = 0; m_v = 0; end
            7: begin r = a ^ l; m_c = 0; m_v = 0; end
            5: begin r = (a * 2) & 255; m_c = (a >= 128); m_v = 0; end
            6: begin r = a / 2; m_c = (a % 2 == 1); m_v = 0; end
            default: wr = 0;
        endcase
        if (wr) begin
            m_acc = r;
            m_z   = (r == 0);
            m_n   = (r >= 128);
        end
        if (op == 10 || (op == 11 && m_z) || (op == 12 && m_c) || (op == 13 && m_n))
            m_pc = l % 64;
        if (op == 15) m_halt = 1;
    endtask

    function automatic bit exp_req();
        return rst_n && run && !m_pend && !m_halt;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc = 0; m_pc = 0; m_ir = 0;
            m_z = 0; m_c = 0; m_n = 0; m_v = 0;
            m_pend = 0; m_halt = 0;
        end else if (m_pend) begin
            m_pend = 0;
            m_exec();
        end else if (exp_req() && instr_valid) begin
            m_ir   = int'(instr_data);
            m_pc   = (m_pc + 1) % 64;
            m_pend = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fetch_req", 32'(fetch_req), 32'(exp_req()));
            if (exp_req()) chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
            chk("acc_out", 32'(acc_out), 32'(m_acc));
            chk("flags", 32'({zero_f, carry_f, negative_f, overflow_f}),
                32'({m_z, m_c, m_n, m_v}));
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("halted", 32'(halted), 32'(m_halt));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 0; run = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 12'hF00;
    endtask

    task automatic run_to_halt(output int cyc);
        run = 1;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1 cyc++;
            if (halted === 1'b1) break;
            if (cyc > 400) begin
                chk("halt_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Pins both the DUT and the model to hand-computed values
    task automatic pin(input string nm, input int acc_e, input int fl_e, input int pc_e);
        chk({nm, "_acc"}, 32'(acc_out), 32'(acc_e));
        chk({nm, "_acc_model"}, 32'(m_acc), 32'(acc_e));
        chk({nm, "_flags"}, 32'({zero_f, carry_f, negative_f, overflow_f}), 32'(fl_e));
        chk({nm, "_flags_model"}, 32'({m_z, m_c, m_n, m_v}), 32'(fl_e));
        if (pc_e >= 0) chk({nm, "_pc"}, 32'(pc_out), 32'(pc_e));
    endtask

    int cyc, nreq;

    initial begin
        rst_n = 0;
        run   = 0;
        clear_mem();
        mem[0] = 12'h47F; mem[1] = 12'h001;
        @(posedge clk);
        #1 chk_en = 1;

        do_reset();
        pin("idle", 0, 0, 0);
        chk("idle_req", 32'(fetch_req), 0);
        run = 1;
        #1 chk("run_req", 32'(fetch_req), 1);
        chk("run_addr", 32'(fetch_addr), 0);

        // ADD overflow, zero-wait throughput
        do_reset(); run_to_halt(cyc);
        pin("add_ovf", 'h80, 4'b0011, 3);
        chk("cyc_zero_wait", 32'(cyc), 6);

        mem[2] = 12'h080;
        do_reset(); run_to_halt(cyc);
        pin("add_wrap", 'h00, 4'b1101, 4);

        clear_mem();
        mem[0] = 12'h405; mem[1] = 12'h103;
        do_reset(); run_to_halt(cyc);
        pin("sub", 'hFE, 4'b0110, 3);
        mem[2] = 12'h900;
        do_reset(); run_to_halt(cyc);
        pin("sbc", 'h01, 4'b0100, 4);

        clear_mem();
        mem[0] = 12'h481; mem[1] = 12'h500;
        do_reset(); run_to_halt(cyc);
        pin("shl", 'h02, 4'b0100, 3);
        mem[2] = 12'h600;
        do_reset(); run_to_halt(cyc);
        pin("shr", 'h01, 4'b0000, 4);

        clear_mem();
        mem[0] = 12'h405; mem[1] = 12'hB10;
        mem[16] = 12'h433; mem[17] = 12'hF00;
        do_reset(); run_to_halt(cyc);
        pin("jz_not", 'h05, 4'b0000, 3);
        mem[0] = 12'h400;
        do_reset(); run_to_halt(cyc);
        pin("jz_taken", 'h33, 4'b0000, 'h12);

        clear_mem();
        mem[0] = 12'hB05; mem[1] = 12'h400; mem[2] = 12'hA3F;
        mem[63] = 12'hE00;
        do_reset(); run_to_halt(cyc);
        pin("pc_wrap", 'h00, 4'b1000, 6);

        // Wait states, halt hold-off and restart
        clear_mem();
        mem[0] = 12'h47F; mem[1] = 12'h001;
        waits = 3;
        do_reset(); run_to_halt(cyc);
        chk("cyc_wait3", 32'(cyc), 15);
        pin("wait3", 'h80, 4'b0011, 3);
        nreq = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (fetch_req !== 1'b0) nreq++;
        end
        chk("halt_no_fetch", 32'(nreq), 0);
        chk("halt_held", 32'(halted), 1);
        do_reset();
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_halted", 32'(halted), 0);
        run = 1;
        #1 chk("resume_req", 32'(fetch_req), 1);

        // Randomized programs, waits, run toggles and resets
        for (int i = 0; i < 64; i++) begin
            mem[i] = 12'($urandom);
            if (mem[i][11:8] == 4'hF && ($urandom % 4 != 0)) mem[i][11:8] = 4'hE;
        end
        for (int t = 0; t < 4000; t++) begin
            @(posedge clk);
            #1;
            run   = ($urandom % 8 != 0);
            rst_n = ($urandom % 150 != 0);
            waits = $urandom % 3;
        end
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
